// File: rtl/ad_ip_jesd204_tpl_dac_channel_mux.sv
// ad_ip_jesd204_tpl_dac_channel_mux
// Per-channel source select for the JESD204 TPL DAC. Each link_clk beat picks
// DDS, DMA, constant pattern, zero or PN data and registers one beat of
// NUM_SAMPLES 16-bit samples for the framer.
//
// Optional feature macro: AD_TPL_DAC_PN_EN
//   defined   : sel 4/5 generate PN7 (x^7+x^6+1) / PN15 (x^15+x^14+1).
//   undefined : no LFSR is built, sel 4/5 output zeros, dac_sync is ignored.
//
// Handshake: dma_ready is a combinational decode of dac_data_sel == DMA. While
// it is high a beat is consumed every cycle; dma_valid low in that cycle is an
// underflow (zero beat plus a one-cycle dac_dunf pulse). There is no stalling.
module ad_ip_jesd204_tpl_dac_channel_mux #(
    parameter int NUM_SAMPLES = 4,
    localparam int DW = NUM_SAMPLES * 16
) (
    input  logic          link_clk,
    input  logic          link_rstn,
    input  logic          dac_sync,
    input  logic [3:0]    dac_data_sel,
    input  logic          dac_dds_format,
    input  logic [15:0]   dac_pat_data_0,
    input  logic [15:0]   dac_pat_data_1,
    input  logic [DW-1:0] dds_data,
    input  logic [DW-1:0] dma_data,
    input  logic          dma_valid,
    output logic          dma_ready,
    output logic [DW-1:0] dac_data,
    output logic          dac_dunf
);

    localparam logic [3:0] SEL_DDS  = 4'd0;
    localparam logic [3:0] SEL_PAT  = 4'd1;
    localparam logic [3:0] SEL_DMA  = 4'd2;
    localparam logic [3:0] SEL_ZERO = 4'd3;
    localparam logic [3:0] SEL_PN7  = 4'd4;
    localparam logic [3:0] SEL_PN15 = 4'd5;

    // Offset-binary conversion: format 0 flips the sign bit of one sample.
    function automatic logic [15:0] fmt_adj(input logic [15:0] s, input logic fmt);
        return s ^ {~fmt, 15'd0};
    endfunction

    logic [DW-1:0] data_next;
    logic          dunf_next;
    logic [DW-1:0] pn_data;

    assign dma_ready = (dac_data_sel == SEL_DMA);

`ifdef AD_TPL_DAC_PN_EN
    logic [14:0] lfsr;
    logic [14:0] lfsr_next;
    logic [3:0]  sel_d;
    logic        pn_mode;
    logic        reseed;

    assign pn_mode = (dac_data_sel == SEL_PN7) || (dac_data_sel == SEL_PN15);
    // dac_sync and a mode entry coinciding still give a single reseed.
    assign reseed  = dac_sync || (pn_mode && (dac_data_sel != sel_d));

    // Unroll 16*NUM_SAMPLES LFSR steps; the reseed beat starts from all ones
    // so it already carries the first word of the seeded sequence.
    always_comb begin : pn_gen
        logic [14:0] s;
        logic [15:0] word;
        logic        fb;
        s         = reseed ? '1 : lfsr;
        word      = '0;
        fb        = 1'b0;
        pn_data   = '0;
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            for (int j = 0; j < 16; j++) begin
                fb   = (dac_data_sel == SEL_PN15) ? (s[14] ^ s[13]) : (s[6] ^ s[5]);
                s    = {s[13:0], fb};
                word = {word[14:0], fb};
            end
            pn_data[16*k +: 16] = word;
        end
        if (pn_mode) begin
            lfsr_next = s;
        end else if (reseed) begin
            lfsr_next = '1;
        end else begin
            lfsr_next = lfsr;
        end
    end

    // LFSR state and previous select, used to detect entry into a PN mode.
    always_ff @(posedge link_clk or negedge link_rstn) begin
        if (!link_rstn) begin
            lfsr  <= '1;
            sel_d <= SEL_ZERO;
        end else begin
            lfsr  <= lfsr_next;
            sel_d <= dac_data_sel;
        end
    end
`else
    logic unused_sync;
    assign unused_sync = dac_sync;
    assign pn_data     = '0;
`endif

    // Source mux for the next beat; zero and PN data bypass the format flip.
    always_comb begin
        data_next = '0;
        dunf_next = 1'b0;
        case (dac_data_sel)
            SEL_DDS: begin
                for (int k = 0; k < NUM_SAMPLES; k++) begin
                    data_next[16*k +: 16] = fmt_adj(dds_data[16*k +: 16], dac_dds_format);
                end
            end
            SEL_PAT: begin
                for (int k = 0; k < NUM_SAMPLES; k++) begin
                    data_next[16*k +: 16] = fmt_adj((k % 2 == 1) ? dac_pat_data_1 : dac_pat_data_0,
                                                    dac_dds_format);
                end
            end
            SEL_DMA: begin
                if (dma_valid) begin
                    for (int k = 0; k < NUM_SAMPLES; k++) begin
                        data_next[16*k +: 16] = fmt_adj(dma_data[16*k +: 16], dac_dds_format);
                    end
                end else begin
                    dunf_next = 1'b1;
                end
            end
            SEL_PN7, SEL_PN15: begin
                data_next = pn_data;
            end
            default: begin
                data_next = '0;
            end
        endcase
    end

    // Output register toward the framer.
    always_ff @(posedge link_clk or negedge link_rstn) begin
        if (!link_rstn) begin
            dac_data <= '0;
            dac_dunf <= 1'b0;
        end else begin
            dac_data <= data_next;
            dac_dunf <= dunf_next;
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_mux.sv
// Bench for ad_ip_jesd204_tpl_dac_channel_mux (NUM_SAMPLES = 4).
// Reference model: per-beat expectation from the source rules, PN bits from
// the recurrence b[n] = b[n-L] ^ b[n-L+1] over a bit history queue.
module tb_ad_ip_jesd204_tpl_dac_channel_mux;

    localparam int NS = 4;
    localparam int DW = NS * 16;

    // ---------------- clock / reset / DUT ----------------
    logic          link_clk = 1'b0;
    logic          link_rstn;
    logic          dac_sync;
    logic [3:0]    dac_data_sel;
    logic          dac_dds_format;
    logic [15:0]   dac_pat_data_0;
    logic [15:0]   dac_pat_data_1;
    logic [DW-1:0] dds_data;
    logic [DW-1:0] dma_data;
    logic          dma_valid;
    logic          dma_ready;
    logic [DW-1:0] dac_data;
    logic          dac_dunf;

    always #5 link_clk = ~link_clk;

    ad_ip_jesd204_tpl_dac_channel_mux #(.NUM_SAMPLES(NS)) dut (
        .link_clk       (link_clk),
        .link_rstn      (link_rstn),
        .dac_sync       (dac_sync),
        .dac_data_sel   (dac_data_sel),
        .dac_dds_format (dac_dds_format),
        .dac_pat_data_0 (dac_pat_data_0),
        .dac_pat_data_1 (dac_pat_data_1),
        .dds_data       (dds_data),
        .dma_data       (dma_data),
        .dma_valid      (dma_valid),
        .dma_ready      (dma_ready),
        .dac_data       (dac_data),
        .dac_dunf       (dac_dunf)
    );

    // ---------------- scoreboard ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_dunf_q[$];
    bit            pn_hist[$];
    logic [3:0]    m_sel_d;
`ifdef AD_TPL_DAC_PN_EN
    localparam bit PN_ON = 1'b1;
`else
    localparam bit PN_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pn_seed();
        pn_hist = {};
        for (int i = 0; i < 15; i++) pn_hist.push_back(1'b1);
    endtask

    task automatic model_reset();
        pn_seed();
        m_sel_d = 4'd3;
        exp_q = {};
        exp_dunf_q = {};
    endtask

    task automatic pn_next(input int len, output bit nb);
        int n;
        n  = pn_hist.size();
        nb = pn_hist[n-len] ^ pn_hist[n-len+1];
        pn_hist.push_back(nb);
        if (pn_hist.size() > 40) void'(pn_hist.pop_front());
    endtask

    // Expected beat for the inputs currently applied.
    task automatic model_beat();
        logic [DW-1:0] d;
        logic [15:0]   smp;
        logic [15:0]   flip;
        bit            nb;
        bit            is_pn;
        d     = '0;
        flip  = dac_dds_format ? 16'h0000 : 16'h8000;
        is_pn = (dac_data_sel == 4'd4) || (dac_data_sel == 4'd5);
        if (PN_ON && (dac_sync || (is_pn && dac_data_sel != m_sel_d))) pn_seed();
        for (int k = 0; k < NS; k++) begin
            smp = 16'h0000;
            if (dac_data_sel == 4'd0) smp = dds_data[16*k +: 16] ^ flip;
            else if (dac_data_sel == 4'd1) smp = ((k % 2) ? dac_pat_data_1 : dac_pat_data_0) ^ flip;
            else if (dac_data_sel == 4'd2 && dma_valid) smp = dma_data[16*k +: 16] ^ flip;
            else if (PN_ON && is_pn) begin
                for (int j = 0; j < 16; j++) begin
                    pn_next((dac_data_sel == 4'd5) ? 15 : 7, nb);
                    smp = {smp[14:0], nb};
                end
            end
            d[16*k +: 16] = smp;
        end
        exp_q.push_back(d);
        exp_dunf_q.push_back(dac_data_sel == 4'd2 && !dma_valid);
        m_sel_d = dac_data_sel;
    endtask

    // ---------------- driver ----------------
    task automatic beat(input string tag);
        logic exp_rdy;
        exp_rdy = (dac_data_sel == 4'd2);
        model_beat();
        @(posedge link_clk);
        #1;
        check({tag, "_rdy"}, {{(DW-1){1'b0}}, dma_ready}, {{(DW-1){1'b0}}, exp_rdy});
        check({tag, "_data"}, dac_data, exp_q.pop_front());
        check({tag, "_dunf"}, {{(DW-1){1'b0}}, dac_dunf}, {{(DW-1){1'b0}}, exp_dunf_q.pop_front()});
    endtask

    function automatic logic [DW-1:0] rnd_wide();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        link_rstn      = 1'b0;
        dac_sync       = 1'b0;
        dac_data_sel   = 4'd3;
        dac_dds_format = 1'b1;
        dac_pat_data_0 = 16'h0;
        dac_pat_data_1 = 16'h0;
        dds_data       = '0;
        dma_data       = '0;
        dma_valid      = 1'b0;
        model_reset();

        // reset values while held in reset
        repeat (2) @(posedge link_clk);
        #1;
        check("rst_data", dac_data, '0);
        check("rst_dunf", {{(DW-1){1'b0}}, dac_dunf}, '0);
        @(negedge link_clk);
        link_rstn = 1'b1;
        #1;
        beat("rst_first");

        // pattern, both formats
        dac_data_sel = 4'd1; dac_pat_data_0 = 16'h1234; dac_pat_data_1 = 16'h5678;
        dac_dds_format = 1'b1;
        beat("pat_f1");
        check("pat_f1_lit", dac_data, 64'h5678_1234_5678_1234);
        dac_dds_format = 1'b0;
        beat("pat_f0");
        check("pat_f0_lit", dac_data, 64'hD678_9234_D678_9234);

        // DMA with an underflow in the middle
        dac_data_sel = 4'd2; dac_dds_format = 1'b1; dma_data = 64'h0004_0003_0002_0001;
        dma_valid = 1'b1; beat("dma_v1");
        check("dma_v1_lit", dac_data, 64'h0004_0003_0002_0001);
        dma_valid = 1'b0; beat("dma_v0");
        check("dma_v0_lit", dac_data, '0);
        check("dma_v0_dunf", {{(DW-1){1'b0}}, dac_dunf}, 64'd1);
        dma_valid = 1'b1; beat("dma_v1b");
        check("dma_v1b_dunf", {{(DW-1){1'b0}}, dac_dunf}, '0);

        // DDS then ZERO: clean switch
        dac_data_sel = 4'd0; dds_data = {NS{16'h7FFF}};
        beat("dds_last");
        check("dds_last_lit", dac_data, {NS{16'h7FFF}});
        dac_data_sel = 4'd3;
        beat("zero_first");
        check("zero_first_lit", dac_data, '0);

`ifdef AD_TPL_DAC_PN_EN
        // PN7 then PN15, dac_sync at beat 10 restarts each sequence
        for (int m = 4; m <= 5; m++) begin
            dac_data_sel = 4'(m);
            for (int b = 0; b < 20; b++) begin
                dac_sync = (b == 10);
                beat((m == 4) ? "pn7" : "pn15");
                if (b == 0 || b == 10)
                    check((m == 4) ? "pn7_w0" : "pn15_w0", {48'd0, dac_data[15:0]},
                          (m == 4) ? 64'h020C : 64'h0002);
            end
            dac_sync = 1'b0;
        end
`else
        // PN disabled: PN15 selection yields zeros, sync has no effect
        dac_data_sel = 4'd5;
        for (int b = 0; b < 100; b++) begin
            dac_sync = ($urandom_range(0, 7) == 0);
            beat("pn_off");
        end
        dac_sync = 1'b0;
`endif

        // asynchronous reset in the middle of DMA traffic
        dac_data_sel = 4'd2; dma_valid = 1'b1; dma_data = rnd_wide() | 64'h1;
        beat("pre_rst");
        #2;
        link_rstn = 1'b0;
        #1;
        check("midrst_data", dac_data, '0);
        check("midrst_dunf", {{(DW-1){1'b0}}, dac_dunf}, '0);
        @(negedge link_clk);
        link_rstn = 1'b1;
        model_reset();
        #1;

        // randomized traffic; select held for a few beats so PN runs continue
        for (int b = 0; b < 400; b++) begin
            if ($urandom_range(0, 3) == 0) dac_data_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) dac_data_sel = 4'($urandom_range(0, 5));
            dac_dds_format = 1'($urandom_range(0, 1));
            dac_pat_data_0 = 16'($urandom());
            dac_pat_data_1 = 16'($urandom());
            dds_data       = rnd_wide();
            dma_data       = rnd_wide();
            dma_valid      = ($urandom_range(0, 3) != 0);
            dac_sync       = ($urandom_range(0, 15) == 0);
            beat("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
